axi4lite_cmd_master: RTL and testbench
======================================

// Module: axi4lite_cmd_master
// PURPOSE
// - Simple-command-to-AXI4-Lite bridge; sits directly upstream of the AXI4-Lite slave / reg_bank stage.
// - Accepts one read or write command, runs one AXI4-Lite transaction, returns data and response.
// - One outstanding transaction at a time; no pipelining across commands.
// PARAMETERS
// - AXI_ADDR_WIDTH  32   address width of CMD_ADDR / AW_ADDR / AR_ADDR
// - AXI_DATA_WIDTH  32   data width of CMD_WDATA / W_DATA / R_DATA / RSP_RDATA
// - TIMEOUT_CYCLES  256  watchdog limit in cycles; used only with AXI_MASTER_TIMEOUT_EN
// PORTS
// - A_CLK      in   1    clock; all logic on rising edge
// - A_RST      in   1    asynchronous, active-high reset
// - CMD_VALID  in   1    command valid
// - CMD_READY  out  1    command accepted when CMD_VALID && CMD_READY
// - CMD_WRITE  in   1    1 = write, 0 = read
// - CMD_ADDR   in   AW   transaction address
// - CMD_WDATA  in   DW   write data; ignored for reads
// - RSP_VALID  out  1    response valid
// - RSP_READY  in   1    response consumed when RSP_VALID && RSP_READY
// - RSP_RDATA  out  DW   read data; 0 for writes
// - RSP_RESP   out  2    BRESP/RRESP of the transaction
// - AW_VALID/AW_READY/AW_ADDR, W_VALID/W_READY/W_DATA, B_VALID/B_READY/B_RESP,
//   AR_VALID/AR_READY/AR_ADDR, R_VALID/R_READY/R_DATA/R_RESP: AXI4-Lite master side, standard directions
// BEHAVIOUR
// - Reset (async, A_RST=1): state IDLE; all AXI VALID/READY, CMD_READY and RSP_VALID = 0; RSP_RDATA, RSP_RESP, latched addr/data = 0.
// - FSM states: IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, DONE.
// - IDLE: CMD_READY=1. On accept, latch addr/wdata/write; go to WR_REQ (write) or RD_ADDR (read).
// - WR_REQ: AW_VALID and W_VALID asserted the cycle after accept, driven from latched regs.
//   - Each VALID held with stable payload until its own handshake, then deasserted (per-channel done flag).
//   - AW and W may complete in any order or in the same cycle. Both done -> WR_RESP.
// - WR_RESP: B_READY=1. On B handshake, capture B_RESP, RSP_RDATA=0 -> DONE.
// - RD_ADDR: AR_VALID=1 until AR handshake -> RD_DATA.
// - RD_DATA: R_READY=1. On R handshake, capture R_DATA/R_RESP -> DONE.
// - DONE: RSP_VALID=1, payload stable until RSP_READY -> IDLE. A new command is not accepted in the same cycle.
// - VALIDs never depend combinationally on AXI READYs; no AXI output is driven outside its state.
// - Minimum latency against a zero-wait slave: accept -> RSP_VALID = 3 cycles for write and read.
// - Reset mid-transaction: all VALIDs drop immediately, FSM returns to IDLE, and the in-flight command is lost without a response.
// - RESP values are passed through unchanged; SLVERR/DECERR are not treated as errors internally.
// CONFIGURATION
// - Macro AXI_MASTER_TIMEOUT_EN defined:
//   - Counter clears on command accept and counts every cycle in WR_REQ/WR_RESP/RD_ADDR/RD_DATA.
//   - At count == TIMEOUT_CYCLES-1, all VALIDs are deasserted and the FSM goes to DONE with RSP_RESP=2'b10, RSP_RDATA=0.
//   - B_READY and R_READY are also held 1 in IDLE, so stray late responses are sunk and discarded.
// - Macro undefined: no counter, and no AXI READY is asserted in IDLE; the block waits indefinitely.
// TESTING
// - Write 0xDEADBEEF to 0x04, then read 0x04, against axi4lite_slave+reg_bank -> RSP_RESP=00 for both, read RSP_RDATA=0xDEADBEEF.
// - Slave raises W_READY 3 cycles before AW_READY -> W_VALID drops after W handshake, AW_VALID holds, one B, one RSP.
// - AW and W handshake in the same cycle -> WR_RESP next cycle, no duplicate beats.
// - B_READY/R_READY stalls: slave delays B_VALID 5 cycles; RSP_READY held low 4 cycles -> RSP payload stable, CMD_READY=0 until consumed.
// - A_RST pulse while in RD_DATA -> AR_VALID/R_READY/RSP_VALID=0 immediately, CMD_READY=1 after reset release.
// - With AXI_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts AR_READY -> RSP_VALID at cycle 16 after accept, RSP_RESP=2'b10.

Source files
------------

// File: rtl/axi4lite_cmd_master.sv
// Single-command to AXI4-Lite master bridge, one transaction in flight.
// Optional watchdog enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi4lite_cmd_master #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      A_CLK,
  input  logic                      A_RST,
  input  logic                      CMD_VALID,
  output logic                      CMD_READY,
  input  logic                      CMD_WRITE,
  input  logic [AXI_ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [AXI_DATA_WIDTH-1:0] CMD_WDATA,
  output logic                      RSP_VALID,
  input  logic                      RSP_READY,
  output logic [AXI_DATA_WIDTH-1:0] RSP_RDATA,
  output logic [1:0]                RSP_RESP,
  output logic                      AW_VALID,
  input  logic                      AW_READY,
  output logic [AXI_ADDR_WIDTH-1:0] AW_ADDR,
  output logic                      W_VALID,
  input  logic                      W_READY,
  output logic [AXI_DATA_WIDTH-1:0] W_DATA,
  input  logic                      B_VALID,
  output logic                      B_READY,
  input  logic [1:0]                B_RESP,
  output logic                      AR_VALID,
  input  logic                      AR_READY,
  output logic [AXI_ADDR_WIDTH-1:0] AR_ADDR,
  input  logic                      R_VALID,
  output logic                      R_READY,
  input  logic [AXI_DATA_WIDTH-1:0] R_DATA,
  input  logic [1:0]                R_RESP
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, DONE
  } state_t;

  state_t state, state_n;

  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [AXI_DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]                rsp_resp;
  logic                      aw_done;
  logic                      w_done;
  logic                      accept;
  logic                      aw_hs;
  logic                      w_hs;
  logic                      b_hs;
  logic                      r_hs;
  logic                      busy;
  logic                      expire;

  assign accept = CMD_VALID && CMD_READY;
  assign aw_hs  = AW_VALID && AW_READY;
  assign w_hs   = W_VALID && W_READY;
  assign b_hs   = (state == WR_RESP) && B_VALID && B_READY;
  assign r_hs   = (state == RD_DATA) && R_VALID && R_READY;
  assign busy   = (state == WR_REQ) || (state == WR_RESP) ||
                  (state == RD_ADDR) || (state == RD_DATA);

  assign AW_ADDR   = addr_q;
  assign AR_ADDR   = addr_q;
  assign W_DATA    = wdata_q;
  assign RSP_RDATA = rsp_rdata;
  assign RSP_RESP  = rsp_resp;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt;

  assign expire = busy && (cnt == CW'(TIMEOUT_CYCLES - 1));

  // The accept cycle is cycle 0, so the first busy cycle sees a count of 1.
  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= accept ? CW'(1) : '0;
    end else if (busy) begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    CMD_READY = 1'b0;
    RSP_VALID = 1'b0;
    AW_VALID  = 1'b0;
    W_VALID   = 1'b0;
    B_READY   = 1'b0;
    AR_VALID  = 1'b0;
    R_READY   = 1'b0;
    unique case (state)
      IDLE: begin
        CMD_READY = !A_RST;
`ifdef AXI_MASTER_TIMEOUT_EN
        // Sink stray responses from aborted transactions.
        B_READY = !A_RST;
        R_READY = !A_RST;
`endif
        if (CMD_VALID && !A_RST) begin
          state_n = CMD_WRITE ? WR_REQ : RD_ADDR;
        end
      end
      WR_REQ: begin
        AW_VALID = !aw_done;
        W_VALID  = !w_done;
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_n = WR_RESP;
        end
      end
      WR_RESP: begin
        B_READY = 1'b1;
        if (B_VALID) state_n = DONE;
      end
      RD_ADDR: begin
        AR_VALID = 1'b1;
        if (AR_READY) state_n = RD_DATA;
      end
      RD_DATA: begin
        R_READY = 1'b1;
        if (R_VALID) state_n = DONE;
      end
      DONE: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (expire) begin
      AW_VALID = 1'b0;
      W_VALID  = 1'b0;
      AR_VALID = 1'b0;
      B_READY  = 1'b0;
      R_READY  = 1'b0;
      state_n  = DONE;
    end
  end

  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
    end else begin
      if (accept) begin
        addr_q  <= CMD_ADDR;
        wdata_q <= CMD_WDATA;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (b_hs) begin
        rsp_resp  <= B_RESP;
        rsp_rdata <= '0;
      end
      if (r_hs) begin
        rsp_resp  <= R_RESP;
        rsp_rdata <= R_DATA;
      end
      if (expire) begin
        rsp_resp  <= 2'b10;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_cmd_master.sv
// Bench for axi4lite_cmd_master: behavioural slave with programmable
// stalls, response scoreboard, protocol hold checks.
module tb_axi4lite_cmd_master;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 256;
`endif

  logic        A_CLK = 1'b0;
  logic        A_RST;
  logic        CMD_VALID, CMD_READY, CMD_WRITE;
  logic [31:0] CMD_ADDR, CMD_WDATA;
  logic        RSP_VALID, RSP_READY;
  logic [31:0] RSP_RDATA;
  logic [1:0]  RSP_RESP;
  logic        AW_VALID, AW_READY;
  logic [31:0] AW_ADDR;
  logic        W_VALID, W_READY;
  logic [31:0] W_DATA;
  logic        B_VALID, B_READY;
  logic [1:0]  B_RESP;
  logic        AR_VALID, AR_READY;
  logic [31:0] AR_ADDR;
  logic        R_VALID, R_READY;
  logic [31:0] R_DATA;
  logic [1:0]  R_RESP;

  axi4lite_cmd_master #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .A_CLK(A_CLK), .A_RST(A_RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_WRITE(CMD_WRITE), .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP)
  );

  always #5 A_CLK = ~A_CLK;

  int total = 0;
  int bad = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic ar_never;
  logic [1:0] b_code, r_code;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic aw_got, w_got, ar_got;
  logic [31:0] sl_awaddr, sl_wdata, sl_rdata;
  int aw_beats = 0, w_beats = 0, b_beats = 0;
  logic [31:0] mem [0:63];

  assign AW_READY = AW_VALID && !aw_got && (aw_cnt >= aw_dly);
  assign W_READY  = W_VALID && !w_got && (w_cnt >= w_dly);
  assign B_VALID  = aw_got && w_got && (b_cnt >= b_dly);
  assign B_RESP   = b_code;
  assign AR_READY = AR_VALID && !ar_got && !ar_never && (ar_cnt >= ar_dly);
  assign R_VALID  = ar_got && (r_cnt >= r_dly);
  assign R_DATA   = sl_rdata;
  assign R_RESP   = r_code;

  always @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      sl_awaddr <= '0; sl_wdata <= '0; sl_rdata <= '0;
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else begin
      if (AW_VALID && !AW_READY && !aw_got) aw_cnt <= aw_cnt + 1;
      if (AW_VALID && AW_READY) begin
        aw_got <= 1'b1; aw_cnt <= 0; sl_awaddr <= AW_ADDR;
        aw_beats <= aw_beats + 1;
      end
      if (W_VALID && !W_READY && !w_got) w_cnt <= w_cnt + 1;
      if (W_VALID && W_READY) begin
        w_got <= 1'b1; w_cnt <= 0; sl_wdata <= W_DATA;
        w_beats <= w_beats + 1;
      end
      if (aw_got && w_got && !B_VALID) b_cnt <= b_cnt + 1;
      if (B_VALID && B_READY) begin
        aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
        mem[sl_awaddr[7:2]] <= sl_wdata;
        b_beats <= b_beats + 1;
      end
      if (AR_VALID && !AR_READY && !ar_got) ar_cnt <= ar_cnt + 1;
      if (AR_VALID && AR_READY) begin
        ar_got <= 1'b1; ar_cnt <= 0; sl_rdata <= mem[AR_ADDR[7:2]];
      end
      if (ar_got && !R_VALID) r_cnt <= r_cnt + 1;
      if (R_VALID && R_READY) begin
        ar_got <= 1'b0; r_cnt <= 0;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  exp_t exp_q[$];
  logic [31:0] model [logic [31:0]];
  int rsp_seen = 0;
  logic rsp_stall = 0, aw_stall = 0, w_stall = 0, ar_stall = 0;
  logic [31:0] p_rdata, p_awaddr, p_wdata, p_araddr;
  logic [1:0] p_resp;

  always @(negedge A_CLK) begin
    if (A_RST) begin
      rsp_stall <= 1'b0; aw_stall <= 1'b0;
      w_stall <= 1'b0; ar_stall <= 1'b0;
    end else begin : mon
      exp_t e;
      if (RSP_VALID) check("cmd_ready_busy", CMD_READY, 0);
      if (rsp_stall)
        check("rsp_hold", {RSP_VALID, RSP_RESP, RSP_RDATA},
              {1'b1, p_resp, p_rdata});
      if (aw_stall && !RSP_VALID)
        check("aw_hold", {AW_VALID, AW_ADDR}, {1'b1, p_awaddr});
      if (w_stall && !RSP_VALID)
        check("w_hold", {W_VALID, W_DATA}, {1'b1, p_wdata});
      if (ar_stall && !RSP_VALID)
        check("ar_hold", {AR_VALID, AR_ADDR}, {1'b1, p_araddr});
      if (aw_got) check("aw_drop", AW_VALID, 0);
      if (w_got)  check("w_drop", W_VALID, 0);
      if (ar_got) check("ar_drop", AR_VALID, 0);
      if (RSP_VALID && RSP_READY) begin
        if (exp_q.size() == 0) begin
          check("rsp_extra", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", RSP_RDATA, e.rdata);
          check("rsp_resp", RSP_RESP, e.resp);
        end
        rsp_seen <= rsp_seen + 1;
      end
      rsp_stall <= RSP_VALID && !RSP_READY;
      aw_stall  <= AW_VALID && !AW_READY;
      w_stall   <= W_VALID && !W_READY;
      ar_stall  <= AR_VALID && !AR_READY;
      p_rdata <= RSP_RDATA; p_resp <= RSP_RESP;
      p_awaddr <= AW_ADDR; p_wdata <= W_DATA; p_araddr <= AR_ADDR;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_cmd(input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [1:0] resp,
                        input int hold, output int lat);
    exp_t e;
    int n0;
    int k;
    e.rdata = wr ? 32'h0 : (model.exists(addr) ? model[addr] : 32'h0);
    e.resp  = resp;
    if (wr) model[addr] = data;
    exp_q.push_back(e);
    n0 = rsp_seen;
    lat = -1;
    CMD_VALID = 1'b1; CMD_WRITE = wr;
    CMD_ADDR = addr; CMD_WDATA = data;
    RSP_READY = (hold == 0);
    k = 0;
    do begin
      @(negedge A_CLK); k++;
    end while (!CMD_READY && k < 50);
    if (!CMD_READY) begin
      check("cmd_accept_timeout", 0, 1);
      CMD_VALID = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    @(posedge A_CLK); #1;
    CMD_VALID = 1'b0;
    lat = 0;
    do begin
      @(negedge A_CLK); lat++;
    end while (!RSP_VALID && lat < 100);
    if (!RSP_VALID) begin
      check("rsp_timeout", 0, 1);
      void'(exp_q.pop_back());
      return;
    end
    if (hold > 0) begin
      repeat (hold) @(posedge A_CLK);
      #1 RSP_READY = 1'b1;
    end
    @(posedge A_CLK);
    k = 0;
    while (rsp_seen == n0 && k < 20) begin
      @(posedge A_CLK); k++;
    end
    if (rsp_seen == n0) check("rsp_pop_timeout", 0, 1);
    #1 RSP_READY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, a0, w0, b0, n0, k;
    logic wr;
    logic [31:0] addr, data;
    A_RST = 1'b1;
    CMD_VALID = 1'b0; CMD_WRITE = 1'b0;
    CMD_ADDR = '0; CMD_WDATA = '0; RSP_READY = 1'b0;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    ar_never = 1'b0; b_code = 2'b00; r_code = 2'b00;

    repeat (2) @(negedge A_CLK);
    check("rst_ctrl", {CMD_READY, RSP_VALID, AW_VALID, W_VALID,
                       AR_VALID, B_READY, R_READY}, 0);
    check("rst_payload", {RSP_RESP, RSP_RDATA}, 0);
    @(posedge A_CLK); #1 A_RST = 1'b0;
    @(negedge A_CLK);
    check("rst_release_ready", CMD_READY, 1);
    @(posedge A_CLK); #1;

    do_cmd(1'b1, 32'h04, 32'hDEAD_BEEF, 2'b00, 0, lat);
    check("wr_lat", lat, 3);
    do_cmd(1'b0, 32'h04, 32'h0, 2'b00, 0, lat);
    check("rd_lat", lat, 3);

    // W accepted three cycles before AW
    aw_dly = 3;
    a0 = aw_beats; w0 = w_beats; b0 = b_beats;
    do_cmd(1'b1, 32'h08, 32'h1234_5678, 2'b00, 0, lat);
    check("w_early_lat", lat, 6);
    check("w_early_beats", {aw_beats - a0, w_beats - w0, b_beats - b0},
          {32'd1, 32'd1, 32'd1});

    // AW and W together after a stall
    aw_dly = 2; w_dly = 2;
    a0 = aw_beats; w0 = w_beats; b0 = b_beats;
    do_cmd(1'b1, 32'h0C, 32'hCAFE_F00D, 2'b00, 0, lat);
    check("aw_w_same_lat", lat, 5);
    check("aw_w_same_beats", {aw_beats - a0, w_beats - w0, b_beats - b0},
          {32'd1, 32'd1, 32'd1});

    // late B with SLVERR, response held off for 4 cycles
    aw_dly = 0; w_dly = 0; b_dly = 5; b_code = 2'b10;
    do_cmd(1'b1, 32'h10, 32'hA5A5_5A5A, 2'b10, 4, lat);
    check("b_stall_lat", lat, 8);
    b_dly = 0; b_code = 2'b00;

    // read with AR/R stalls and DECERR passthrough
    ar_dly = 2; r_dly = 3; r_code = 2'b11;
    do_cmd(1'b0, 32'h08, 32'h0, 2'b11, 2, lat);
    check("rd_stall_lat", lat, 8);
    ar_dly = 0; r_code = 2'b00;

    // reset while waiting in RD_DATA
    r_dly = 10;
    n0 = rsp_seen;
    CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 32'h04;
    @(negedge A_CLK);
    check("mid_rst_accept", CMD_READY, 1);
    @(posedge A_CLK); #1 CMD_VALID = 1'b0;
    k = 0;
    do begin
      @(negedge A_CLK); k++;
    end while (!R_READY && k < 20);
    check("mid_rst_in_rd_data", R_READY, 1);
    #2 A_RST = 1'b1;
    #1;
    check("mid_rst_outputs", {AR_VALID, R_READY, RSP_VALID, CMD_READY}, 0);
    @(negedge A_CLK);
    @(posedge A_CLK); #1 A_RST = 1'b0;
    model.delete();
    @(negedge A_CLK);
    check("mid_rst_ready", CMD_READY, 1);
    repeat (12) @(negedge A_CLK);
    check("mid_rst_no_rsp", rsp_seen - n0, 0);
    r_dly = 0;
    @(posedge A_CLK); #1;

    // random mix against the memory model
    for (int i = 0; i < 12; i++) begin
      aw_dly = $urandom_range(0, 3);
      w_dly  = $urandom_range(0, 3);
      b_dly  = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3);
      r_dly  = $urandom_range(0, 3);
      wr   = (i < 4) ? 1'b1 : logic'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 15)) << 2;
      data = $urandom;
      do_cmd(wr, addr, data, 2'b00, $urandom_range(0, 2), lat);
    end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;

`ifdef AXI_MASTER_TIMEOUT_EN
    ar_never = 1'b1;
    do_cmd(1'b0, 32'h80, 32'h0, 2'b10, 0, lat);
    check("timeout_lat", lat, 16);
    @(negedge A_CLK);
    check("idle_sink_ready", {B_READY, R_READY}, 2'b11);
    ar_never = 1'b0;
    @(posedge A_CLK); #1;
`endif

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
